// File: rtl/ibex_multdiv_arbiter.sv
// Round-robin arbiter sharing one multi-cycle mult/div unit between NumReq requesters.
// Latches the winner's operands, sequences the unit handshake and returns the result to that owner.
module ibex_multdiv_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq-1:0]       req_is_div_i,
    input  logic [NumReq-1:0][1:0]  req_operator_i,
    input  logic [NumReq-1:0][1:0]  req_signed_mode_i,
    input  logic [NumReq-1:0][31:0] req_op_a_i,
    input  logic [NumReq-1:0][31:0] req_op_b_i,
    input  logic [NumReq-1:0]       req_flush_i,
    output logic [NumReq-1:0]       rsp_valid_o,
    input  logic [NumReq-1:0]       rsp_ready_i,
    output logic [31:0]             rsp_result_o,
    output logic                    rsp_timeout_o,
    output logic                    md_mult_en_o,
    output logic                    md_div_en_o,
    output logic                    md_mult_sel_o,
    output logic                    md_div_sel_o,
    output logic [1:0]              md_operator_o,
    output logic [1:0]              md_signed_mode_o,
    output logic [31:0]             md_op_a_o,
    output logic [31:0]             md_op_b_o,
    output logic                    md_ready_id_o,
    input  logic                    md_valid_i,
    input  logic [31:0]             md_result_i
);
    localparam int unsigned IdxW = (NumReq > 2) ? 2 : 1;
    typedef logic [IdxW-1:0] idx_t;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_e;

    state_e      state_q, state_d;
    idx_t        ptr_q, owner_q, gnt_idx, cand;
    logic        gnt_found;
    logic        is_div_q, timeout_q;
    logic [7:0]  cnt_q;
    logic [31:0] result_q;
    logic        flush_own, timeout_hit, active;

    assign flush_own   = req_flush_i[owner_q];
    assign timeout_hit = (cnt_q == 8'(TimeoutCycles - 1));
    assign active      = ((state_q == BUSY) || (state_q == DRAIN)) && !rst_i;

    // Cyclic search starting just after the last winner; flushed requesters are skipped.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= int'(NumReq); k++) begin
            cand = idx_t'((int'(ptr_q) + k) % int'(NumReq));
            if (!gnt_found && req_valid_i[cand] && !req_flush_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        req_ready_o   = '0;
        rsp_valid_o   = '0;
        rsp_timeout_o = 1'b0;
        md_mult_en_o  = active && !is_div_q;
        md_div_en_o   = active && is_div_q;
        md_mult_sel_o = active && !is_div_q;
        md_div_sel_o  = active && is_div_q;
        md_ready_id_o = active && md_valid_i;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) state_d = BUSY;
                for (int i = 0; i < int'(NumReq); i++)
                    req_ready_o[i] = gnt_found && (gnt_idx == idx_t'(i)) && !rst_i;
            end
            BUSY: begin
                // A flush racing the result kills it outright; otherwise wait out the unit.
                if (md_valid_i)       state_d = flush_own ? IDLE : RESP;
                else if (flush_own)   state_d = timeout_hit ? IDLE : DRAIN;
                else if (timeout_hit) state_d = RESP;
            end
            DRAIN: begin
                if (md_valid_i || timeout_hit) state_d = IDLE;
            end
            RESP: begin
                if (flush_own || rsp_ready_i[owner_q]) state_d = IDLE;
                for (int i = 0; i < int'(NumReq); i++)
                    rsp_valid_o[i] = (owner_q == idx_t'(i)) && !rst_i;
                rsp_timeout_o = timeout_q && !rst_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q            <= idx_t'(NumReq - 1);
            owner_q          <= '0;
            is_div_q         <= 1'b0;
            timeout_q        <= 1'b0;
            cnt_q            <= '0;
            result_q         <= '0;
            md_operator_o    <= '0;
            md_signed_mode_o <= '0;
            md_op_a_o        <= '0;
            md_op_b_o        <= '0;
        end else begin
            if (state_q == IDLE && gnt_found) begin
                ptr_q            <= gnt_idx;
                owner_q          <= gnt_idx;
                is_div_q         <= req_is_div_i[gnt_idx];
                md_operator_o    <= req_operator_i[gnt_idx];
                md_signed_mode_o <= req_signed_mode_i[gnt_idx];
                md_op_a_o        <= req_op_a_i[gnt_idx];
                md_op_b_o        <= req_op_b_i[gnt_idx];
                cnt_q            <= '0;
                timeout_q        <= 1'b0;
            end else if (state_q == BUSY || state_q == DRAIN) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state_q == BUSY && !flush_own) begin
                if (md_valid_i) begin
                    result_q <= md_result_i;
                end else if (timeout_hit) begin
                    result_q  <= '0;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign rsp_result_o = result_q;

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Directed bench for ibex_multdiv_arbiter: transaction-level model checked every cycle,
// plus literal expectations for the scripted scenarios.
module tb_ibex_multdiv_arbiter;
    localparam int NR = 2;
    localparam int TO = 8;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic [NR-1:0]       req_valid_i = '0, req_ready_o, req_is_div_i = '0, req_flush_i = '0;
    logic [NR-1:0][1:0]  req_operator_i = '0, req_signed_mode_i = '0;
    logic [NR-1:0][31:0] req_op_a_i = '0, req_op_b_i = '0;
    logic [NR-1:0]       rsp_valid_o, rsp_ready_i = '0;
    logic [31:0]         rsp_result_o;
    logic                rsp_timeout_o;
    logic                md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o;
    logic [1:0]          md_operator_o, md_signed_mode_o;
    logic [31:0]         md_op_a_o, md_op_b_o;
    logic                md_valid_i = 1'b0;
    logic [31:0]         md_result_i = '0;

    always #5 clk = ~clk;

    ibex_multdiv_arbiter #(.NumReq(NR), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_is_div_i(req_is_div_i),
        .req_operator_i(req_operator_i), .req_signed_mode_i(req_signed_mode_i),
        .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_flush_i(req_flush_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
        .rsp_timeout_o(rsp_timeout_o),
        .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
        .md_mult_sel_o(md_mult_sel_o), .md_div_sel_o(md_div_sel_o),
        .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
        .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o), .md_ready_id_o(md_ready_id_o),
        .md_valid_i(md_valid_i), .md_result_i(md_result_i)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Transaction model: one op in flight, described by who owns it and what happened to it.
    bit          started = 0;
    bit          m_out = 0, m_done = 0, m_killed = 0, m_isdiv = 0, m_to = 0;
    int          m_owner = 0, m_last = NR - 1, m_age = 0;
    logic [31:0] m_a, m_b, m_res;
    logic [1:0]  m_opr, m_sm;

    function automatic int exp_grant();
        if (m_out) return -1;
        for (int k = 1; k <= NR; k++) begin
            int j;
            j = (m_last + k) % NR;
            if (req_valid_i[j] && !req_flush_i[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : mdl
        int g;
        if (rst_i) begin
            started = 1; m_out = 0; m_done = 0; m_killed = 0; m_to = 0; m_last = NR - 1;
            m_a = '0; m_b = '0; m_opr = '0; m_sm = '0;
        end else if (started) begin
            g = exp_grant();
            if (!m_out) begin
                if (g >= 0) begin
                    m_out = 1; m_done = 0; m_killed = 0; m_to = 0; m_age = 0;
                    m_owner = g; m_last = g; m_isdiv = req_is_div_i[g];
                    m_a = req_op_a_i[g]; m_b = req_op_b_i[g];
                    m_opr = req_operator_i[g]; m_sm = req_signed_mode_i[g];
                end
            end else if (m_done) begin
                if (req_flush_i[m_owner] || rsp_ready_i[m_owner]) begin m_out = 0; m_done = 0; end
            end else begin
                if (md_valid_i) begin
                    if (m_killed || req_flush_i[m_owner]) m_out = 0;
                    else begin m_done = 1; m_res = md_result_i; m_to = 0; end
                end else if (req_flush_i[m_owner] && !m_killed) begin
                    if (m_age == TO - 1) m_out = 0; else m_killed = 1;
                end else if (m_age == TO - 1) begin
                    if (m_killed) m_out = 0;
                    else begin m_done = 1; m_res = '0; m_to = 1; end
                end
                m_age++;
            end
        end
    end

    always @(negedge clk) begin : cmp
        int g;
        logic [NR-1:0] er, ev;
        logic em, ed, eid, eto, act;
        if (started) begin
            g   = exp_grant();
            act = m_out && !m_done && !rst_i;
            er  = (g >= 0 && !rst_i) ? NR'(1 << g) : '0;
            ev  = (m_done && !rst_i) ? NR'(1 << m_owner) : '0;
            em  = act && !m_isdiv;
            ed  = act && m_isdiv;
            eid = act && md_valid_i;
            eto = m_done && m_to && !rst_i;
            chk("m_req_ready", req_ready_o, er);
            chk("m_rsp_valid", rsp_valid_o, ev);
            chk("m_rsp_timeout", rsp_timeout_o, eto);
            chk("m_mult_en", md_mult_en_o, em);
            chk("m_div_en", md_div_en_o, ed);
            chk("m_mult_sel", md_mult_sel_o, em);
            chk("m_div_sel", md_div_sel_o, ed);
            chk("m_ready_id", md_ready_id_o, eid);
            if (m_out && !rst_i) begin
                chk("m_op_a", md_op_a_o, m_a);
                chk("m_op_b", md_op_b_o, m_b);
                chk("m_operator", md_operator_o, m_opr);
                chk("m_signed", md_signed_mode_o, m_sm);
            end
            if (m_done && !rst_i) chk("m_result", rsp_result_o, m_res);
        end
    end

    // Unit emulator for the back-to-back scenario: result after two enabled cycles.
    bit auto_unit = 0;
    int ucnt = 0;

    task automatic tick();
        @(posedge clk); #1;
        if (auto_unit) begin
            if (md_mult_en_o || md_div_en_o) begin
                ucnt++;
                md_valid_i  = (ucnt == 2);
                md_result_i = md_op_a_o * md_op_b_o;
                if (ucnt == 2) ucnt = 0;
            end else begin
                ucnt = 0;
                md_valid_i = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int r, input bit dv, input logic [31:0] a, input logic [31:0] b);
        req_valid_i[r]       = 1'b1;
        req_is_div_i[r]      = dv;
        req_operator_i[r]    = dv ? 2'd2 : 2'd0;
        req_signed_mode_i[r] = dv ? 2'd3 : 2'd1;
        req_op_a_i[r]        = a;
        req_op_b_i[r]        = b;
    endtask

    // Raise a request, wait (bounded) for its grant, then drop valid after the handshake edge.
    task automatic issue(input int r, input bit dv, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        set_req(r, dv, a, b);
        #1;
        while (!req_ready_o[r] && w < 20) begin tick(); w++; end
        chk("issue_grant", req_ready_o[r], 1);
        tick();
        req_valid_i[r] = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; tick(); tick(); rst_i = 1'b0; #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int gq[$];
        int nop[NR], nrsp[NR];
        bit hs[NR];
        tick(); tick();
        rst_i = 1'b0; #1;
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_op_a", md_op_a_o, 0);
        chk("rst_mult_en", md_mult_en_o, 0);

        // 1: single mul, result at cycle 3, response at cycle 4
        issue(0, 0, 3, 5);
        chk("t1_mult_en_c1", md_mult_en_o, 1);
        chk("t1_op_a", md_op_a_o, 3);
        tick(); tick();
        md_valid_i = 1'b1; md_result_i = 15; #1;
        chk("t1_ready_id", md_ready_id_o, 1);
        chk("t1_no_rsp_c3", rsp_valid_o, 0);
        tick(); md_valid_i = 1'b0; #1;
        chk("t1_rsp_valid", rsp_valid_o, 2'b01);
        chk("t1_result", rsp_result_o, 15);
        rsp_ready_i = 2'b01; tick(); rsp_ready_i = '0;

        // 2: both requesters streaming, grants must alternate
        do_reset();
        auto_unit = 1; rsp_ready_i = '1;
        for (int r = 0; r < NR; r++) begin
            nop[r] = 0; nrsp[r] = 0;
            set_req(r, 0, 100 * (r + 1), 3);
        end
        for (int c = 0; c < 200 && (nrsp[0] < 4 || nrsp[1] < 4); c++) begin
            #1;
            for (int r = 0; r < NR; r++) begin
                hs[r] = req_valid_i[r] && req_ready_o[r];
                if (hs[r]) begin gq.push_back(r); nop[r]++; end
                if (rsp_valid_o[r]) nrsp[r]++;
            end
            tick();
            for (int r = 0; r < NR; r++)
                if (hs[r]) begin
                    if (nop[r] == 4) req_valid_i[r] = 1'b0;
                    else req_op_a_i[r] = 100 * (r + 1) + nop[r];
                end
        end
        auto_unit = 0; md_valid_i = 1'b0; rsp_ready_i = '0; req_valid_i = '0;
        chk("t2_rsp0", nrsp[0], 4);
        chk("t2_rsp1", nrsp[1], 4);
        chk("t2_ngrants", gq.size(), 8);
        for (int i = 0; i < gq.size() && i < 8; i++) chk("t2_grant_order", gq[i], i % 2);
        tick();

        // 3: req1 div flushed in its second BUSY cycle, drained until the unit finishes
        issue(1, 1, 100, 7);
        tick();
        req_flush_i[1] = 1'b1;
        tick(); req_flush_i[1] = 1'b0; #1;
        chk("t3_drain_en_c3", md_div_en_o, 1);
        tick(); tick();
        md_valid_i = 1'b1; md_result_i = 99; #1;
        chk("t3_drain_en_c5", md_div_en_o, 1);
        chk("t3_no_rsp_c5", rsp_valid_o, 0);
        tick(); md_valid_i = 1'b0; #1;
        chk("t3_idle_en", md_div_en_o, 0);
        chk("t3_no_rsp_c6", rsp_valid_o, 0);

        // 4: unit never answers, timeout response after 8 BUSY cycles
        issue(0, 0, 7, 9);
        for (int c = 1; c <= 8; c++) begin
            chk("t4_en", md_mult_en_o, 1);
            chk("t4_no_rsp", rsp_valid_o, 0);
            if (c < 8) tick();
        end
        tick();
        chk("t4_rsp_valid", rsp_valid_o, 2'b01);
        chk("t4_timeout", rsp_timeout_o, 1);
        chk("t4_result", rsp_result_o, 0);
        chk("t4_en_drop", md_mult_en_o, 0);
        rsp_ready_i = 2'b01; tick(); rsp_ready_i = '0; #1;
        chk("t4_timeout_clr", rsp_timeout_o, 0);

        // 5: minimum latency, then a back-pressured response blocks req1
        issue(0, 0, 6, 7);
        md_valid_i = 1'b1; md_result_i = 42;
        tick(); md_valid_i = 1'b0; #1;
        chk("t5_min_lat_rsp", rsp_valid_o, 2'b01);
        set_req(1, 0, 8, 2);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("t5_result_stable", rsp_result_o, 42);
            chk("t5_ready_blocked", req_ready_o, 0);
            tick();
        end
        rsp_ready_i = 2'b01; tick(); rsp_ready_i = '0; #1;
        chk("t5_req1_grant", req_ready_o, 2'b10);
        tick(); req_valid_i[1] = 1'b0; #1;
        chk("t5_busy_en", md_mult_en_o, 1);
        chk("t5_op_a", md_op_a_o, 8);

        // 6: reset mid-operation
        rst_i = 1'b1; #1;
        chk("t6_en_drop_same", md_mult_en_o, 0);
        tick(); rst_i = 1'b0; #1;
        chk("t6_rsp_valid", rsp_valid_o, 0);
        chk("t6_op_a", md_op_a_o, 0);
        chk("t6_operator", md_operator_o, 0);
        set_req(0, 0, 11, 7);
        set_req(1, 0, 13, 7);
        #1;
        chk("t6_req0_wins", req_ready_o, 2'b01);
        tick(); req_valid_i = '0;
        md_valid_i = 1'b1; md_result_i = 77;
        tick(); md_valid_i = 1'b0; #1;
        chk("t6_rsp_valid_after", rsp_valid_o, 2'b01);
        chk("t6_result", rsp_result_o, 77);
        rsp_ready_i = 2'b01; tick(); rsp_ready_i = '0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
